// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
//            Optional macro MULDIV_EARLY_TERM_EN: early multiply exit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
    parameter int NB_DATA  = 32,
    parameter int NB_OP    = 2,
    parameter int NB_COUNT = $clog2(NB_DATA) + 1
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_operand_a,
    input  logic [NB_DATA-1:0] i_operand_b,
    input  logic               i_flush,
    input  logic               i_hi_we,
    input  logic               i_lo_we,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic               i_hilo_access,
    output logic               o_busy,
    output logic               o_stall,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [NB_COUNT-1:0] C_COUNT_LOAD = NB_COUNT'(NB_DATA);
    localparam logic [NB_COUNT-1:0] C_COUNT_ONE  = NB_COUNT'(1);
    localparam logic [NB_DATA-1:0]  C_ZERO       = '0;
    localparam logic [NB_DATA-1:0]  C_ONES       = {NB_DATA{1'b1}};

    state_t                 state_q,     state_d;
    logic [NB_COUNT-1:0]    count_q,     count_d;
    logic [2*NB_DATA-1:0]   acc_q,       acc_d;
    logic [2*NB_DATA-1:0]   mcand_q,     mcand_d;
    logic [NB_DATA-1:0]     mplier_q,    mplier_d;
    logic                   is_div_q,    is_div_d;
    logic                   is_signed_q, is_signed_d;
    logic                   sign_a_q,    sign_a_d;
    logic                   sign_b_q,    sign_b_d;
    logic                   div0_q,      div0_d;
    logic [NB_DATA-1:0]     hi_q,        hi_d;
    logic [NB_DATA-1:0]     lo_q,        lo_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;

    logic                   w_op_signed;
    logic [NB_DATA-1:0]     w_abs_a;
    logic [NB_DATA-1:0]     w_abs_b;
    logic [NB_DATA:0]       w_rem_sh;
    logic [NB_DATA:0]       w_divisor;
    logic [NB_DATA:0]       w_rem_diff;
    logic                   w_rem_ge;
    logic [2*NB_DATA-1:0]   w_prod_next;
    logic [NB_DATA-1:0]     w_mplier_next;
    logic                   w_last;
    logic [2*NB_DATA-1:0]   w_prod_fix;
    logic [NB_DATA-1:0]     w_quot_fix;
    logic [NB_DATA-1:0]     w_rem_fix;
    logic [2*NB_DATA-1:0]   w_result;

    // Signed operations run on magnitudes; signs are restored in FIX.
    assign w_op_signed = ~i_op[0];
    assign w_abs_a = (w_op_signed && i_operand_a[NB_DATA-1]) ? -i_operand_a : i_operand_a;
    assign w_abs_b = (w_op_signed && i_operand_b[NB_DATA-1]) ? -i_operand_b : i_operand_b;

    // Divide keeps {remainder, dividend/quotient} in acc; divisor sits in mcand low half.
    assign w_rem_sh   = {acc_q[2*NB_DATA-1:NB_DATA], acc_q[NB_DATA-1]};
    assign w_divisor  = {1'b0, mcand_q[NB_DATA-1:0]};
    assign w_rem_diff = w_rem_sh - w_divisor;
    assign w_rem_ge   = (w_rem_sh >= w_divisor);

    assign w_prod_next   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign w_mplier_next = mplier_q >> 1;

`ifdef MULDIV_EARLY_TERM_EN
    assign w_last = (count_q == C_COUNT_ONE) || (!is_div_q && (w_mplier_next == C_ZERO));
`else
    assign w_last = (count_q == C_COUNT_ONE);
`endif

    assign w_prod_fix = (is_signed_q && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
    assign w_quot_fix = (is_signed_q && (sign_a_q ^ sign_b_q)) ? -acc_q[NB_DATA-1:0]
                                                               :  acc_q[NB_DATA-1:0];
    assign w_rem_fix  = (is_signed_q && sign_a_q) ? -acc_q[2*NB_DATA-1:NB_DATA]
                                                  :  acc_q[2*NB_DATA-1:NB_DATA];

    always_comb begin
        w_result = w_prod_fix;
        if (div0_q) begin
            w_result = acc_q;
        end else if (is_div_q) begin
            w_result = {w_rem_fix, w_quot_fix};
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        div0_d      = div0_q;
        hi_d        = hi_q;
        lo_d        = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (i_hi_we) hi_d = i_wr_data;
                if (i_lo_we) lo_d = i_wr_data;
                if (i_start) begin
                    is_div_d    = i_op[1];
                    is_signed_d = w_op_signed;
                    sign_a_d    = w_op_signed & i_operand_a[NB_DATA-1];
                    sign_b_d    = w_op_signed & i_operand_b[NB_DATA-1];
                    count_d     = C_COUNT_LOAD;
                    div0_d      = 1'b0;
                    if (i_op[1] && (i_operand_b == C_ZERO)) begin
                        div0_d  = 1'b1;
                        acc_d   = {i_operand_a, C_ONES};
                        state_d = ST_FIX;
                    end else if (i_op[1]) begin
                        acc_d   = {C_ZERO, w_abs_a};
                        mcand_d = {C_ZERO, w_abs_b};
                        state_d = ST_CALC;
                    end else begin
                        acc_d    = '0;
                        mcand_d  = {C_ZERO, w_abs_a};
                        mplier_d = w_abs_b;
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (i_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q - C_COUNT_ONE;
                    if (is_div_q) begin
                        acc_d = w_rem_ge ? {w_rem_diff[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1}
                                         : {w_rem_sh[NB_DATA-1:0],   acc_q[NB_DATA-2:0], 1'b0};
                    end else begin
                        acc_d    = w_prod_next;
                        mcand_d  = mcand_q << 1;
                        mplier_d = w_mplier_next;
                    end
                    if (w_last) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (i_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d    = w_result[2*NB_DATA-1:NB_DATA];
                    lo_d    = w_result[NB_DATA-1:0];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            div0_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            div0_q      <= div0_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_stall = busy_q & i_hilo_access;
    assign o_done  = done_q;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Scoreboard bench for muldiv_sequencer (directed vectors).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_flush, i_hi_we, i_lo_we, i_hilo_access;
    logic [1:0]  i_op;
    logic [31:0] i_a, i_b, i_wr_data;
    logic        o_busy, o_stall, o_done;
    logic [31:0] o_hi, o_lo;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          done_cyc;
        string       name;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          lat_et;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[10];

    muldiv_sequencer dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_start      (i_start),
        .i_op         (i_op),
        .i_operand_a  (i_a),
        .i_operand_b  (i_b),
        .i_flush      (i_flush),
        .i_hi_we      (i_hi_we),
        .i_lo_we      (i_lo_we),
        .i_wr_data    (i_wr_data),
        .i_hilo_access(i_hilo_access),
        .o_busy       (o_busy),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_hi         (o_hi),
        .o_lo         (o_lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every o_done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: o_done=1 at cyc=%0d, want no result", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if (o_hi !== mon_e.hi || o_lo !== mon_e.lo || cyc != mon_e.done_cyc) begin
                    failures++;
                    $display("FAIL %s: got hi=%h lo=%h cyc=%0d, want hi=%h lo=%h cyc=%0d",
                             mon_e.name, o_hi, o_lo, cyc, mon_e.hi, mon_e.lo, mon_e.done_cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] hi, input logic [31:0] lo,
                         input int lat, input string name, output int sc);
        step();
        i_start = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        sc      = cyc;
        if (push) sb_q.push_back('{hi: hi, lo: lo, done_cyc: sc + lat, name: name});
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: o_done pending after %0d cycles, want done", name, n);
            sb_q.delete();
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int lat;
        string nm;

        vecs = '{
            '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 34},
            '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 34},
            '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF,  2,  2},
            '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 34},
            '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 34, 34},
            '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34, 34},
            '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34, 34},
            '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF,  2,  2},
            '{2'b01, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 34,  5},
            '{2'b01, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 34,  3}
        };

        rst_n = 1'b0;
        i_start = 1'b0; i_flush = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
        i_hilo_access = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0; i_wr_data = '0;
        step();
        step();
        chk("reset_hi",   o_hi, 32'h0);
        chk("reset_lo",   o_lo, 32'h0);
        chk("reset_busy", {31'b0, o_busy}, 32'h0);
        chk("reset_done", {31'b0, o_done}, 32'h0);
        rst_n = 1'b1;
        step();

        // MTLO then simultaneous MTHI/MTLO in IDLE.
        i_lo_we = 1'b1; i_wr_data = 32'h00001234;
        step();
        i_lo_we = 1'b0;
        chk("mtlo", o_lo, 32'h00001234);
        i_hi_we = 1'b1; i_lo_we = 1'b1; i_wr_data = 32'hAAAA5555;
        step();
        i_hi_we = 1'b0; i_lo_we = 1'b0;
        chk("mthi_both", o_hi, 32'hAAAA5555);
        chk("mtlo_both", o_lo, 32'hAAAA5555);
        i_hilo_access = 1'b1;
        #1;
        chk("stall_idle", {31'b0, o_stall}, 32'h0);
        i_hilo_access = 1'b0;

        // MULT -3 * 7 with busy/stall observation.
`ifdef MULDIV_EARLY_TERM_EN
        lat = 5;
`else
        lat = 34;
`endif
        issue(2'b00, 32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB,
              lat, "mult_neg3x7", sc);
        chk("busy_cyc1", {31'b0, o_busy}, 32'h1);
        i_hilo_access = 1'b1;
        #1;
        chk("stall_calc", {31'b0, o_stall}, 32'h1);
        i_hilo_access = 1'b0;
`ifndef MULDIV_EARLY_TERM_EN
        while (cyc < sc + 33) step();
        chk("busy_cyc33", {31'b0, o_busy}, 32'h1);
        step();
        chk("busy_cyc34", {31'b0, o_busy}, 32'h0);
`endif
        wait_drain("mult_neg3x7");

        for (int i = 0; i < 10; i++) begin
            nm = $sformatf("vec%0d", i);
`ifdef MULDIV_EARLY_TERM_EN
            lat = vecs[i].lat_et;
`else
            lat = vecs[i].lat;
`endif
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].hi, vecs[i].lo, lat, nm, sc);
            wait_drain(nm);
        end

        // Flush of a DIVU at cycle 10; MTHI while busy must be dropped.
        i_hi_we = 1'b1; i_lo_we = 1'b1; i_wr_data = 32'h11111111;
        step();
        i_hi_we = 1'b0; i_lo_we = 1'b0;
        issue(2'b11, 32'h000003E8, 32'h00000003, 1'b0, 32'h0, 32'h0, 0, "divu_flush", sc);
        while (cyc < sc + 3) step();
        i_hi_we = 1'b1; i_wr_data = 32'hDEADBEEF;
        step();
        i_hi_we = 1'b0;
        while (cyc < sc + 10) step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("flush_busy", {31'b0, o_busy}, 32'h0);
        chk("flush_hi", o_hi, 32'h11111111);
        chk("flush_lo", o_lo, 32'h11111111);
        repeat (40) step();
        chk("flush_hi_later", o_hi, 32'h11111111);

        // Asynchronous reset in the middle of a MULT.
        issue(2'b00, 32'h00012345, 32'h7FFFFFFF, 1'b0, 32'h0, 32'h0, 0, "mult_reset", sc);
        while (cyc < sc + 5) step();
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", {31'b0, o_busy}, 32'h0);
        chk("midreset_hi", o_hi, 32'h0);
        chk("midreset_lo", o_lo, 32'h0);
        #1;
        rst_n = 1'b1;

`ifdef MULDIV_EARLY_TERM_EN
        lat = 5;
`else
        lat = 34;
`endif
        issue(2'b01, 32'h00000003, 32'h00000005, 1'b1, 32'h0, 32'h0000000F,
              lat, "multu_after_reset", sc);
        wait_drain("multu_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
